pipeline_stage_reg: RTL and testbench

//  Generic inter-stage pipeline register with valid/ready handshake, hazard stall and flush.

---
 rtl/pipeline_stage_reg_pkg.sv | 49 ++++
 rtl/pipeline_stage_reg_if.sv | 22 ++
 rtl/pipeline_stage_reg_skid_buf.sv | 42 ++++
 rtl/pipeline_stage_reg.sv | 110 +++++++++++
 tb/tb_pipeline_stage_reg.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_stage_reg_pkg.sv
// Shared CPU pipeline types: stage-control decode, per-stage payload layouts and the bubble word.
// Imported by the pipeline register and its skid-buffer option (macro PIPE_SKID_EN).
package cpu_types_pkg;

    typedef enum logic [1:0] {
        PIPE_ENABLE = 2'd0,
        PIPE_STALL  = 2'd1,
        PIPE_NOP    = 2'd2
    } pipe_state_t;

    // Bubble encoding loaded on reset and flush; stages that need a real NOP override NOP_VAL.
    localparam logic [63:0] NOP_INSTR = 64'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fd_payload_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [5:0]  op;
        logic [31:0] imm;
    } de_payload_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
        logic [31:0] alu_res;
        logic [31:0] store_val;
    } em_payload_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic        wb_en;
        logic [31:0] wb_val;
    } mw_payload_t;

    // Flush outranks stall, which outranks a normal transfer.
    function automatic pipe_state_t decode_pipe_state(input logic flush, input logic stall);
        if (flush) return PIPE_NOP;
        if (stall) return PIPE_STALL;
        return PIPE_ENABLE;
    endfunction

endpackage

// File: rtl/pipeline_stage_reg_if.sv
// Valid/ready handshake bundle for one pipeline stage: upstream side and downstream side.
// master = the surrounding pipeline (or bench), slave = the stage register itself.
interface pipeline_stage_reg_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipeline_stage_reg_skid_buf.sv
// One-entry holding register with full flag; the second slot of the stage when PIPE_SKID_EN is set.
module pipe_skid_buf #(
    parameter int DATA_W = 64
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              clr,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] wdata,
    output logic              full,
    output logic [DATA_W-1:0] rdata
);
    logic              full_q, full_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (clr) begin
            full_d = 1'b0;
        end else if (wr) begin
            full_d = 1'b1;
            data_d = wdata;
        end else if (rd) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full  = full_q;
    assign rdata = data_q;
endmodule

// File: rtl/pipeline_stage_reg.sv
// Inter-stage pipeline register: valid/ready handshake, hazard stall, flush, bubble statistics.
// Define PIPE_SKID_EN to add a skid entry so in_ready no longer depends on out_ready.
module pipeline_stage_reg
    import cpu_types_pkg::*;
#(
    parameter int                DATA_W  = 64,
    parameter logic [DATA_W-1:0] NOP_VAL = DATA_W'(NOP_INSTR),
    parameter int                STAT_W  = 16
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  flush,
    input  logic                  stall,
    pipeline_stage_reg_if.slave   bus,
    output logic [1:0]            occupancy,
    output logic [STAT_W-1:0]     stat_bubbles
);
    pipe_state_t       state;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [STAT_W-1:0] stat_q, stat_d;
    logic              accept;
    logic              consume;

    assign state   = decode_pipe_state(flush, stall);
    // A stalled stage keeps out_valid high but must not hand its payload on.
    assign consume = (state == PIPE_ENABLE) && out_valid_q && bus.out_ready;
    assign accept  = bus.in_valid && bus.in_ready;

`ifdef PIPE_SKID_EN
    logic              skid_full;
    logic              skid_wr;
    logic              skid_rd;
    logic [DATA_W-1:0] skid_data;

    assign bus.in_ready = (state == PIPE_ENABLE) && !skid_full;
    assign skid_wr      = accept && out_valid_q && !consume;
    assign skid_rd      = consume && skid_full;
    assign occupancy    = 2'(out_valid_q) + 2'(skid_full);

    pipe_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .CLK   (CLK),
        .nRST  (nRST),
        .clr   (state == PIPE_NOP),
        .wr    (skid_wr),
        .rd    (skid_rd),
        .wdata (bus.in_data),
        .full  (skid_full),
        .rdata (skid_data)
    );
`else
    assign bus.in_ready = (state == PIPE_ENABLE) && (!out_valid_q || bus.out_ready);
    assign occupancy    = 2'(out_valid_q);
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        unique case (state)
            PIPE_NOP: begin
                out_valid_d = 1'b0;
                out_data_d  = NOP_VAL;
            end
            PIPE_STALL: begin
            end
            PIPE_ENABLE: begin
`ifdef PIPE_SKID_EN
                // A full skid blocks input, so draining it never races with an accept.
                if (skid_rd) begin
                    out_valid_d = 1'b1;
                    out_data_d  = skid_data;
                end else
`endif
                if (accept && (!out_valid_q || consume)) begin
                    out_valid_d = 1'b1;
                    out_data_d  = bus.in_data;
                end else if (consume) begin
                    out_valid_d = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        stat_d = stat_q;
        if (bus.out_ready && !out_valid_q && !stall && (stat_q != '1)) begin
            stat_d = stat_q + STAT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            out_valid_q <= 1'b0;
            out_data_q  <= NOP_VAL;
            stat_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            stat_q      <= stat_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign stat_bubbles  = stat_q;
endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Self-checking bench for pipeline_stage_reg: vector table, directed corner sequences and
// random traffic against a queue-based reference model; adapts to PIPE_SKID_EN.
module tb_pipeline_stage_reg;
    localparam int         DW  = 8;
    localparam logic [7:0] NOP = 8'h5A;
    localparam int         SW  = 2;
    localparam int         SAT = (1 << SW) - 1;
`ifdef PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          CLK   = 1'b0;
    logic          nRST  = 1'b0;
    logic          flush = 1'b0;
    logic          stall = 1'b0;
    logic [1:0]    occupancy;
    logic [SW-1:0] stat_bubbles;

    pipeline_stage_reg_if #(.DATA_W(DW)) bus ();

    pipeline_stage_reg #(
        .DATA_W  (DW),
        .NOP_VAL (NOP),
        .STAT_W  (SW)
    ) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .flush        (flush),
        .stall        (stall),
        .bus          (bus.slave),
        .occupancy    (occupancy),
        .stat_bubbles (stat_bubbles)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the stage is a FIFO of at most CAP payloads; out_data shows the head,
    // or the most recently consumed payload (NOP after reset/flush) when empty.
    logic [7:0] mq[$];
    logic [7:0] m_last = NOP;
    int         m_bub  = 0;

    function automatic bit m_rdy();
        if (flush || stall) return 1'b0;
        if (CAP == 2) return mq.size() < 2;
        return (mq.size() == 0) || bus.out_ready;
    endfunction

    task automatic m_reset();
        mq.delete();
        m_last = NOP;
        m_bub  = 0;
    endtask

    task automatic m_edge();
        bit r;
        r = m_rdy();
        if (bus.out_ready && mq.size() == 0 && !stall && m_bub < SAT) m_bub++;
        if (flush) begin
            mq.delete();
            m_last = NOP;
        end else if (!stall) begin
            if (bus.out_ready && mq.size() > 0) m_last = mq.pop_front();
            if (bus.in_valid && r) mq.push_back(bus.in_data);
        end
    endtask

    task automatic drive(input bit iv, input logic [7:0] d, input bit ordy, input bit st, input bit fl);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        stall         = st;
        flush         = fl;
    endtask

    // One clock: check in_ready before the edge, advance model, check registered outputs after.
    task automatic cyc(input string tag);
        logic [7:0] exp_d;
        #1;
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(m_rdy()));
        m_edge();
        @(posedge CLK);
        #1;
        exp_d = (mq.size() > 0) ? mq[0] : m_last;
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(mq.size() > 0));
        chk({tag, ".out_data"}, 32'(bus.out_data), 32'(exp_d));
        chk({tag, ".occupancy"}, 32'(occupancy), 32'(mq.size()));
        chk({tag, ".stat"}, 32'(stat_bubbles), 32'(m_bub));
        $display("[%0t] %s iv=%0b d=%h ordy=%0b st=%0b fl=%0b -> ov=%0b od=%h occ=%0d bub=%0d",
                 $time, tag, bus.in_valid, bus.in_data, bus.out_ready, stall, flush,
                 bus.out_valid, bus.out_data, occupancy, stat_bubbles);
    endtask

    typedef struct {
        bit         iv;
        logic [7:0] d;
        bit         ordy;
        bit         st;
        bit         fl;
        bit         rdy;
        bit         ov;
        logic [7:0] od;
        logic [1:0] occ;
    } vec_t;

    function automatic vec_t mk(bit iv, logic [7:0] d, bit ordy, bit st, bit fl,
                                bit rdy, bit ov, logic [7:0] od, logic [1:0] occ);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.st = st; v.fl = fl;
        v.rdy = rdy; v.ov = ov; v.od = od; v.occ = occ;
        return v;
    endfunction

    vec_t tbl[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        //            iv  d      ordy st fl   rdy ov od     occ
        tbl[0]  = mk(1, 8'h01, 1, 0, 0,   1, 1, 8'h01, 2'd1);
        tbl[1]  = mk(1, 8'h02, 1, 0, 0,   1, 1, 8'h02, 2'd1);
        tbl[2]  = mk(1, 8'h03, 1, 0, 0,   1, 1, 8'h03, 2'd1);
        tbl[3]  = mk(0, 8'h00, 1, 0, 0,   1, 0, 8'h03, 2'd0);
        tbl[4]  = mk(1, 8'h11, 0, 0, 0,   1, 1, 8'h11, 2'd1);
        tbl[5]  = mk(0, 8'h00, 0, 1, 0,   0, 1, 8'h11, 2'd1);
        tbl[6]  = mk(0, 8'h00, 1, 1, 0,   0, 1, 8'h11, 2'd1);
        tbl[7]  = mk(1, 8'h44, 1, 1, 0,   0, 1, 8'h11, 2'd1);
        tbl[8]  = mk(1, 8'h55, 1, 1, 1,   0, 0, NOP,   2'd0);
        tbl[9]  = mk(1, 8'h66, 1, 0, 1,   0, 0, NOP,   2'd0);
        tbl[10] = mk(1, 8'h77, 0, 0, 0,   1, 1, 8'h77, 2'd1);
        tbl[11] = mk(0, 8'h00, 1, 0, 0,   1, 0, 8'h77, 2'd0);

        // Reset held with a live input offered
        nRST = 1'b0;
        drive(1, 8'hA5, 0, 0, 0);
        repeat (3) @(posedge CLK);
        #1;
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.out_data", 32'(bus.out_data), 32'(NOP));
        chk("rst.occupancy", 32'(occupancy), 32'd0);
        chk("rst.stat", 32'(stat_bubbles), 32'd0);
        nRST = 1'b1;
        m_reset();

        // Vector table: stream, consume-only, stall, stall+flush, flush dropping input
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].st, tbl[i].fl);
            #1;
            chk($sformatf("tbl%0d.in_ready", i), 32'(bus.in_ready), 32'(tbl[i].rdy));
            m_edge();
            @(posedge CLK);
            #1;
            chk($sformatf("tbl%0d.out_valid", i), 32'(bus.out_valid), 32'(tbl[i].ov));
            chk($sformatf("tbl%0d.out_data", i), 32'(bus.out_data), 32'(tbl[i].od));
            chk($sformatf("tbl%0d.occupancy", i), 32'(occupancy), 32'(tbl[i].occ));
            $display("[%0t] tbl%0d ov=%0b od=%h occ=%0d", $time, i,
                     bus.out_valid, bus.out_data, occupancy);
        end

        // Backpressure: 0x11 held, 0x22 offered
        drive(1, 8'h11, 0, 0, 0);
        cyc("bp_load");
        drive(1, 8'h22, 0, 0, 0);
        cyc("bp_offer");
        chk("bp.hold_data", 32'(bus.out_data), 32'h11);
        chk("bp.occ", 32'(occupancy), 32'(CAP));
        chk("bp.in_ready_low", 32'(bus.in_ready), 32'd0);
        cyc("bp_hold");
        chk("bp.still_11", 32'(bus.out_data), 32'h11);
        drive(0, 8'h00, 1, 0, 0);
        cyc("bp_drain1");
`ifdef PIPE_SKID_EN
        chk("bp.drain1_valid", 32'(bus.out_valid), 32'd1);
        chk("bp.drain1_data", 32'(bus.out_data), 32'h22);
`else
        chk("bp.drain1_valid", 32'(bus.out_valid), 32'd0);
        chk("bp.drain1_data", 32'(bus.out_data), 32'h11);
`endif
        cyc("bp_drain2");
        chk("bp.drain2_valid", 32'(bus.out_valid), 32'd0);

        // Stall for 3 cycles with a full stage, then stall and flush together
        drive(1, 8'h33, 0, 0, 0);
        cyc("sf_load");
        drive(1, 8'h44, 0, 0, 0);
        cyc("sf_offer");
        drive(1, 8'h55, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc("sf_stall");
            chk("sf.stall_data", 32'(bus.out_data), 32'h33);
            chk("sf.stall_valid", 32'(bus.out_valid), 32'd1);
            chk("sf.stall_occ", 32'(occupancy), 32'(CAP));
            chk("sf.stall_rdy", 32'(bus.in_ready), 32'd0);
        end
        drive(1, 8'h55, 1, 1, 1);
        cyc("sf_flush");
        chk("sf.flush_valid", 32'(bus.out_valid), 32'd0);
        chk("sf.flush_data", 32'(bus.out_data), 32'(NOP));
        chk("sf.flush_occ", 32'(occupancy), 32'd0);

        // Bubble counter: frozen under stall, then saturates at 3
        #2 nRST = 1'b0;
        #1 nRST = 1'b1;
        m_reset();
        drive(0, 8'h00, 1, 1, 0);
        repeat (5) cyc("bub_stall");
        chk("bub.stalled", 32'(stat_bubbles), 32'd0);
        drive(0, 8'h00, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc("bub_run");
            chk("bub.count", 32'(stat_bubbles), (i < 3) ? 32'(i + 1) : 32'd3);
        end

        // Asynchronous reset pulse between edges while full under backpressure
        drive(1, 8'h66, 0, 0, 0);
        cyc("ar_load");
        drive(1, 8'h77, 0, 0, 0);
        cyc("ar_offer");
        chk("ar.occ_before", 32'(occupancy), 32'(CAP));
        #2 nRST = 1'b0;
        #1;
        chk("ar.valid_now", 32'(bus.out_valid), 32'd0);
        chk("ar.occ_now", 32'(occupancy), 32'd0);
        chk("ar.data_now", 32'(bus.out_data), 32'(NOP));
        nRST = 1'b1;
        m_reset();
        drive(0, 8'h00, 1, 0, 0);
        cyc("ar_after");
        chk("ar.no_stale", 32'(bus.out_valid), 32'd0);
        chk("ar.ready", 32'(bus.in_ready), 32'd1);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 6,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
            cyc("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
